// File: rtl/calc_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// calc_seq_ctrl_pkg
// Shared definitions for the switch/key calculator sequencer: opcode values,
// FSM state encoding, the error display word and the green LED pattern shown
// in each state.
// No ports (package).
// ---------------------------------------------------------------------------
package calc_seq_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_SHOW,
        ST_ERR
    } state_t;

    localparam logic [31:0] ERR_WORD = 32'hEEEE_EEEE;

    localparam logic [2:0] LEDG_GET_A = 3'b001;
    localparam logic [2:0] LEDG_GET_B = 3'b010;
    localparam logic [2:0] LEDG_EXEC  = 3'b000;
    localparam logic [2:0] LEDG_SHOW  = 3'b100;
    localparam logic [2:0] LEDG_ERR   = 3'b111;

    // LED pattern for a state; used when loading the registered LEDG value
    // together with the state transition.
    function automatic logic [2:0] ledg_for(input state_t st);
        logic [2:0] pat;
        case (st)
            ST_GET_A: pat = LEDG_GET_A;
            ST_GET_B: pat = LEDG_GET_B;
            ST_EXEC:  pat = LEDG_EXEC;
            ST_SHOW:  pat = LEDG_SHOW;
            ST_ERR:   pat = LEDG_ERR;
            default:  pat = LEDG_GET_A;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// calc_seq_ctrl_if
// Board-facing signal bundle of the calculator sequencer.
//   SW    [W+1:0]  operand value SW[W-1:0], opcode SW[W+1:W]
//   KEY1           ENTER pushbutton, active-low, asynchronous
//   KEY2           CLEAR pushbutton, active-low, asynchronous
//   DATA  [2W-1:0] hex word for the seven-segment decoders
//   LEDG  [2:0]    state indicator
//   LEDG3          SUB result negative
//   BUSY           high while executing
// master: board/stimulus side, slave: sequencer side.
// ---------------------------------------------------------------------------
interface calc_seq_ctrl_if #(
    parameter int W = 16
);
    logic [W+1:0]   SW;
    logic           KEY1;
    logic           KEY2;
    logic [2*W-1:0] DATA;
    logic [2:0]     LEDG;
    logic           LEDG3;
    logic           BUSY;

    modport master (
        output SW, KEY1, KEY2,
        input  DATA, LEDG, LEDG3, BUSY
    );

    modport slave (
        input  SW, KEY1, KEY2,
        output DATA, LEDG, LEDG3, BUSY
    );
endinterface

// File: rtl/calc_seq_ctrl_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises an active-low pushbutton into the clock domain and emits a
// single-cycle pulse once the key has been sampled low for DEB_CYCLES
// consecutive cycles. The key must be seen high again before another pulse.
// Ports:
//   CLOCK_50  in  system clock
//   RST_N     in  asynchronous active-low reset
//   key_n     in  raw active-low key, asynchronous
//   press_p   out one-cycle registered press pulse
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic RST_N,
    input  logic key_n,
    output logic press_p
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= 2'b11;          // released
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            press_q <= 1'b0;
            if (sync_q[1]) begin
                cnt_q <= '0;           // any high sample restarts the count and re-arms
            end else if (cnt_q != CW'(DEB_CYCLES)) begin
                // Saturating at DEB_CYCLES keeps a held key from pulsing again.
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    press_q <= 1'b1;
                end
            end
        end
    end

    assign press_p = press_q;
endmodule

// File: rtl/calc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// calc_seq_ctrl
// Sequencer for the switch/key calculator: operand-A entry, operand-B entry,
// execution (single-cycle add/sub, iterative shift-add multiply and
// restoring divide) and result display.
// Ports:
//   CLOCK_50  in  system clock
//   RST_N     in  asynchronous active-low reset
//   bus       calc_seq_ctrl_if.slave (SW, KEY1, KEY2 in; DATA, LEDG, LEDG3, BUSY out)
// DATA is registered except in GET_A/GET_B, where it shows the live switches.
// ---------------------------------------------------------------------------
module calc_seq_ctrl
    import calc_seq_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000,
    parameter int W          = 16
) (
    input  logic           CLOCK_50,
    input  logic           RST_N,
    calc_seq_ctrl_if.slave bus
);
    localparam int DW = 2 * W;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] ITER_LAST = IW'(W - 1);

    // ---- key pulses -------------------------------------------------------
    logic [1:0] keys_n;
    logic [1:0] press_p;
    logic       enter_p;
    logic       clear_p;

    assign keys_n = {bus.KEY2, bus.KEY1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .CLOCK_50 (CLOCK_50),
                .RST_N    (RST_N),
                .key_n    (keys_n[gi]),
                .press_p  (press_p[gi])
            );
        end
    endgenerate

    assign enter_p = press_p[0];
    assign clear_p = press_p[1];

    // ---- state ------------------------------------------------------------
    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [1:0]      op_q;
    logic [DW-1:0]   data_q;
    logic [2:0]      ledg_q;
    logic            ledg3_q;
    logic            busy_q;
    logic [IW-1:0]   iter_q;
    logic            first_q;     // first EXEC cycle: single-cycle ops / iteration setup
    logic [DW-1:0]   prod_q;
    logic [DW-1:0]   mcand_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;

    // ---- datapath -----------------------------------------------------------
    logic [W:0]      add_sum;
    logic [W:0]      sub_diff;
    logic [DW-1:0]   prod_d;
    logic [W:0]      rem_shift;
    logic [W-1:0]    rem_trial;
    logic            rem_fits;
    logic [W-1:0]    rem_d;
    logic [W-1:0]    quo_d;
    logic            goto_a;

    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff = {1'b0, a_q} - {1'b0, b_q};

    // Shift-add: multiplicand shifts left each step, multiplier bit picked by iteration.
    assign prod_d = prod_q + (b_q[iter_q] ? mcand_q : '0);

    // Restoring divide: bring down the next dividend bit from the quotient register.
    // The partial remainder is < 2*B, so the trial difference fits in W bits when it is kept.
    assign rem_shift = {rem_q, quo_q[W-1]};
    assign rem_fits  = (rem_shift >= {1'b0, b_q});
    assign rem_trial = rem_shift[W-1:0] - b_q;
    assign rem_d     = rem_fits ? rem_trial : rem_shift[W-1:0];
    assign quo_d     = {quo_q[W-2:0], rem_fits};

    // Clear wins over enter; enter leaves SHOW/ERR for a fresh entry.
    assign goto_a = clear_p | (enter_p & ((state_q == ST_SHOW) | (state_q == ST_ERR)));

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            data_q  <= '0;
            ledg_q  <= LEDG_GET_A;
            ledg3_q <= 1'b0;
            busy_q  <= 1'b0;
            iter_q  <= '0;
            first_q <= 1'b0;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else if (goto_a) begin
            state_q <= ST_GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            data_q  <= '0;
            ledg_q  <= ledg_for(ST_GET_A);
            ledg3_q <= 1'b0;
            busy_q  <= 1'b0;
            iter_q  <= '0;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                ST_GET_A: begin
                    if (enter_p) begin
                        a_q     <= bus.SW[W-1:0];
                        state_q <= ST_GET_B;
                        ledg_q  <= ledg_for(ST_GET_B);
                    end
                end
                ST_GET_B: begin
                    if (enter_p) begin
                        b_q     <= bus.SW[W-1:0];
                        op_q    <= bus.SW[W+1:W];
                        data_q  <= {a_q, bus.SW[W-1:0]};
                        state_q <= ST_EXEC;
                        ledg_q  <= ledg_for(ST_EXEC);
                        busy_q  <= 1'b1;
                        iter_q  <= '0;
                        first_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                        case (op_q)
                            OP_ADD: begin
                                data_q  <= {{(W-1){1'b0}}, add_sum};
                                state_q <= ST_SHOW;
                                ledg_q  <= ledg_for(ST_SHOW);
                                busy_q  <= 1'b0;
                            end
                            OP_SUB: begin
                                data_q  <= {{(W-1){sub_diff[W]}}, sub_diff};
                                ledg3_q <= (a_q < b_q);
                                state_q <= ST_SHOW;
                                ledg_q  <= ledg_for(ST_SHOW);
                                busy_q  <= 1'b0;
                            end
                            OP_MUL: begin
                                prod_q  <= '0;
                                mcand_q <= {{W{1'b0}}, a_q};
                            end
                            default: begin // OP_DIV
                                if (b_q == '0) begin
                                    data_q  <= DW'(ERR_WORD);
                                    state_q <= ST_ERR;
                                    ledg_q  <= ledg_for(ST_ERR);
                                    busy_q  <= 1'b0;
                                end else begin
                                    rem_q <= '0;
                                    quo_q <= a_q;
                                end
                            end
                        endcase
                    end else begin
                        if (op_q == OP_MUL) begin
                            prod_q  <= prod_d;
                            mcand_q <= {mcand_q[DW-2:0], 1'b0};
                        end else begin
                            rem_q <= rem_d;
                            quo_q <= quo_d;
                        end
                        if (iter_q == ITER_LAST) begin
                            data_q  <= (op_q == OP_MUL) ? prod_d : {quo_d, rem_d};
                            state_q <= ST_SHOW;
                            ledg_q  <= ledg_for(ST_SHOW);
                            busy_q  <= 1'b0;
                        end else begin
                            iter_q <= iter_q + 1'b1;
                        end
                    end
                end
                default: ; // SHOW / ERR only leave through goto_a
            endcase
        end
    end

    // ---- outputs ------------------------------------------------------------
    assign bus.DATA  = (state_q == ST_GET_A) ? {{W{1'b0}}, bus.SW[W-1:0]} :
                       (state_q == ST_GET_B) ? {a_q, bus.SW[W-1:0]}       :
                                               data_q;
    assign bus.LEDG  = ledg_q;
    assign bus.LEDG3 = ledg3_q;
    assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_seq_ctrl
// Self-checking bench for calc_seq_ctrl with a short debounce window.
// Expected results come from a behavioural model pushed into a scoreboard
// queue when an operation is entered and popped when the display settles.
// ---------------------------------------------------------------------------
module tb_calc_seq_ctrl;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  ledg;
        logic        ledg3;
        int          busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   busy_total;
    exp_t sb[$];

    calc_seq_ctrl_if #(.W(16)) cif ();

    calc_seq_ctrl #(
        .DEB_CYCLES (4),
        .W          (16)
    ) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of falling edges at which BUSY was high.
    initial busy_total = 0;
    always @(negedge clk) if (cif.BUSY === 1'b1) busy_total <= busy_total + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        exp_t e;
        e.ledg  = 3'b100;
        e.ledg3 = 1'b0;
        e.busy  = 1;
        e.data  = 32'h0;
        case (op)
            2'b00: e.data = 32'(a) + 32'(b);
            2'b01: begin
                e.data  = 32'(a) - 32'(b);
                e.ledg3 = (a < b);
            end
            2'b10: begin
                e.data = 32'(a) * 32'(b);
                e.busy = 17;
            end
            default: begin
                if (b == 16'h0) begin
                    e.data = 32'hEEEE_EEEE;
                    e.ledg = 3'b111;
                end else begin
                    e.data = {a / b, a % b};
                    e.busy = 17;
                end
            end
        endcase
        return e;
    endfunction

    task automatic press(input bit which);
        if (which) cif.KEY2 = 1'b0; else cif.KEY1 = 1'b0;
        repeat (12) @(negedge clk);
        cif.KEY1 = 1'b1;
        cif.KEY2 = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        exp_t e;
        int   t0;
        int   n;
        int   bc;
        e = model(a, b, op);
        sb.push_back(e);
        cif.SW = {2'b00, a};
        @(negedge clk);
        press(1'b0);
        tests++; if (cif.LEDG !== 3'b010) begin fails++; $display("FAIL op_get_b_ledg: got %b want 010", cif.LEDG); end
        cif.SW = {op, b};
        @(negedge clk);
        tests++; if (cif.DATA !== {a, b}) begin fails++; $display("FAIL op_get_b_data: got %h want %h", cif.DATA, {a, b}); end
        t0 = busy_total;
        press(1'b0);
        n = 0;
        while (cif.LEDG !== 3'b100 && cif.LEDG !== 3'b111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++; if (n >= 100) begin fails++; $display("FAIL op_timeout: ledg %b after %0d cycles, want 100/111", cif.LEDG, n); end
        e  = sb.pop_front();
        bc = busy_total - t0;
        $display("[TB] op=%0d a=%h b=%h data=%h ledg=%b ledg3=%b busy=%0d", op, a, b, cif.DATA, cif.LEDG, cif.LEDG3, bc);
        tests++; if (cif.DATA !== e.data) begin fails++; $display("FAIL op_data: got %h want %h", cif.DATA, e.data); end
        tests++; if (cif.LEDG !== e.ledg) begin fails++; $display("FAIL op_ledg: got %b want %b", cif.LEDG, e.ledg); end
        tests++; if (cif.LEDG3 !== e.ledg3) begin fails++; $display("FAIL op_ledg3: got %b want %b", cif.LEDG3, e.ledg3); end
        tests++; if (bc !== e.busy) begin fails++; $display("FAIL op_busy_cycles: got %0d want %0d", bc, e.busy); end
        tests++; if (cif.BUSY !== 1'b0) begin fails++; $display("FAIL op_busy_after: got %b want 0", cif.BUSY); end
        press(1'b0);
        tests++; if (cif.LEDG !== 3'b001) begin fails++; $display("FAIL op_back_get_a: got %b want 001", cif.LEDG); end
        tests++; if (cif.LEDG3 !== 1'b0) begin fails++; $display("FAIL op_ledg3_cleared: got %b want 0", cif.LEDG3); end
    endtask

    // Enter A, then B with the MUL opcode, and hold ENTER until BUSY rises.
    task automatic start_mul(input logic [15:0] a, input logic [15:0] b, output int t0);
        int n;
        cif.SW = {2'b00, a};
        @(negedge clk);
        press(1'b0);
        cif.SW = {2'b10, b};
        t0 = busy_total;
        cif.KEY1 = 1'b0;
        n = 0;
        while (cif.BUSY !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++; if (cif.BUSY !== 1'b1) begin fails++; $display("FAIL mul_busy_start: got %b want 1", cif.BUSY); end
        tests++; if (cif.LEDG !== 3'b000) begin fails++; $display("FAIL exec_ledg: got %b want 000", cif.LEDG); end
        tests++; if (cif.DATA !== {a, b}) begin fails++; $display("FAIL exec_data: got %h want %h", cif.DATA, {a, b}); end
        cif.KEY1 = 1'b1;
    endtask

    task automatic test_reset();
        cif.SW   = 18'h2ABCD;
        cif.KEY1 = 1'b1;
        cif.KEY2 = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (cif.LEDG !== 3'b001) begin fails++; $display("FAIL reset_ledg: got %b want 001", cif.LEDG); end
        tests++; if (cif.LEDG3 !== 1'b0) begin fails++; $display("FAIL reset_ledg3: got %b want 0", cif.LEDG3); end
        tests++; if (cif.BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", cif.BUSY); end
        tests++; if (cif.DATA !== 32'h0000_ABCD) begin fails++; $display("FAIL reset_data: got %h want 0000abcd", cif.DATA); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (cif.LEDG !== 3'b001) begin fails++; $display("FAIL post_reset_ledg: got %b want 001", cif.LEDG); end
        cif.SW = 18'h0_5A5A;
        @(negedge clk);
        tests++; if (cif.DATA !== 32'h0000_5A5A) begin fails++; $display("FAIL live_sw_data: got %h want 00005a5a", cif.DATA); end
        $display("[TB] reset checked");
    endtask

    task automatic test_bounce();
        int gb_entries;
        logic [2:0] prev;
        gb_entries = 0;
        cif.SW = 18'h0_1111;
        prev = cif.LEDG;
        for (int i = 0; i < 5; i++) begin
            cif.KEY1 = 1'b0;
            repeat (2) @(negedge clk);
            cif.KEY1 = 1'b1;
            repeat (2) @(negedge clk);
        end
        tests++; if (cif.LEDG !== 3'b001) begin fails++; $display("FAIL bounce_no_press: got %b want 001", cif.LEDG); end
        cif.KEY1 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (prev !== 3'b010 && cif.LEDG === 3'b010) gb_entries++;
            prev = cif.LEDG;
        end
        tests++; if (gb_entries !== 1) begin fails++; $display("FAIL bounce_entries: got %0d want 1", gb_entries); end
        tests++; if (cif.LEDG !== 3'b010) begin fails++; $display("FAIL bounce_held_ledg: got %b want 010", cif.LEDG); end
        cif.SW = 18'h0_2222;
        @(negedge clk);
        tests++; if (cif.DATA !== 32'h1111_2222) begin fails++; $display("FAIL bounce_data: got %h want 11112222", cif.DATA); end
        cif.KEY1 = 1'b1;
        repeat (6) @(negedge clk);
        press(1'b1);
        tests++; if (cif.LEDG !== 3'b001) begin fails++; $display("FAIL clear_get_b_ledg: got %b want 001", cif.LEDG); end
        tests++; if (cif.DATA !== 32'h0000_2222) begin fails++; $display("FAIL clear_get_b_data: got %h want 00002222", cif.DATA); end
        $display("[TB] bounce checked, entries=%0d", gb_entries);
    endtask

    task automatic test_add();
        run_op(16'hFFFF, 16'h0001, 2'b00);
    endtask

    task automatic test_sub();
        run_op(16'h0003, 16'h0005, 2'b01);
        run_op(16'hFFFF, 16'h0000, 2'b01);
    endtask

    task automatic test_mul_div();
        run_op(16'hFFFF, 16'hFFFF, 2'b10);
        run_op(16'd100, 16'd7, 2'b11);
        run_op(16'h0003, 16'hFFFF, 2'b11);
    endtask

    task automatic test_div_zero();
        run_op(16'h1234, 16'h0000, 2'b11);
    endtask

    task automatic test_abort_clear();
        int t0;
        int n;
        int bc;
        start_mul(16'hFFFF, 16'h00FF, t0);
        repeat (3) @(negedge clk);
        cif.KEY2 = 1'b0;
        n = 0;
        while (cif.LEDG !== 3'b001 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bc = busy_total - t0;
        tests++; if (cif.LEDG !== 3'b001) begin fails++; $display("FAIL abort_clear_ledg: got %b want 001", cif.LEDG); end
        tests++; if (cif.BUSY !== 1'b0) begin fails++; $display("FAIL abort_clear_busy: got %b want 0", cif.BUSY); end
        tests++; if (cif.DATA !== 32'h0000_00FF) begin fails++; $display("FAIL abort_clear_data: got %h want 000000ff", cif.DATA); end
        tests++; if (bc < 2 || bc > 16) begin fails++; $display("FAIL abort_clear_midway: busy cycles %0d want 2..16", bc); end
        $display("[TB] clear abort after %0d busy cycles", bc);
        cif.KEY2 = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_abort_reset();
        int t0;
        start_mul(16'h00FF, 16'h0F0F, t0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (cif.LEDG !== 3'b001) begin fails++; $display("FAIL abort_rst_ledg: got %b want 001", cif.LEDG); end
        tests++; if (cif.BUSY !== 1'b0) begin fails++; $display("FAIL abort_rst_busy: got %b want 0", cif.BUSY); end
        tests++; if (cif.LEDG3 !== 1'b0) begin fails++; $display("FAIL abort_rst_ledg3: got %b want 0", cif.LEDG3); end
        tests++; if (cif.DATA !== 32'h0000_0F0F) begin fails++; $display("FAIL abort_rst_data: got %h want 00000f0f", cif.DATA); end
        $display("[TB] reset abort checked");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(16'h1234, 16'h4321, 2'b00);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        for (int i = 0; i < 6; i++) begin
            a  = 16'($urandom);
            b  = (i == 5) ? 16'h0 : 16'($urandom);
            op = 2'(i % 4);
            if (i == 5) op = 2'b11;
            run_op(a, b, op);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        cif.SW   = '0;
        cif.KEY1 = 1'b1;
        cif.KEY2 = 1'b1;
        test_reset();
        test_bounce();
        test_add();
        test_sub();
        test_mul_div();
        test_div_zero();
        test_abort_clear();
        test_abort_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
